lu_serial_arbiter: RTL and testbench
====================================

LU_SERIAL_ARBITER -- requirements
Module: lu_serial_arbiter

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, rst_n; rst_n SHALL be asynchronous and active-low.
REQ-002 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 wants an operation
- op0  in  2  requester 0 opcode
- a0, b0  in  WIDTH  requester 0 operands
- gnt0  out  1  one-cycle pulse: requester 0 operands captured
- req1, op1, a1, b1, gnt1  same as above, for requester 1
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse: result valid
- done_id  out  1  requester served by this result (0/1)
- result  out  WIDTH  last completed result

REQ-004 Opcode encoding SHALL be:
- 00 AND
- 01 NAND
- 10 OR
- 11 NOR
- op[0] drives the invert select (ctrl1) and op[1] drives the OR-group select (ctrl2) of the 1-bit logic unit.

Function
REQ-005 The FSM SHALL have three states, IDLE, RUN and DONE, with these transitions:
- IDLE -> RUN when req0 or req1 is high at a rising edge
- RUN -> DONE at the edge where bit counter == WIDTH-1
- DONE -> IDLE unconditionally after one cycle
REQ-006 Requests SHALL be sampled only in IDLE; req, op and operand changes in RUN or DONE SHALL be ignored.
REQ-007 On the IDLE->RUN edge, the block SHALL capture the winner's op, a and b, and SHALL raise gnt of the winner for exactly the following cycle.
REQ-008 gnt0 and gnt1 SHALL never be high together.
REQ-009 Arbitration SHALL be round-robin:
- A single requester always wins.
- When both request, the requester not served last wins.
- The last-served pointer SHALL reset to 1, so req0 wins the first tie.
REQ-010 In RUN, the block SHALL process one bit per cycle through a single 1-bit logic unit, LSB first, in WIDTH cycles total (bit counter 0..WIDTH-1).
REQ-011 The bit computed at counter value i SHALL be stored into bit i of an internal shift/result register.
REQ-012 In DONE:
- done SHALL be 1 for exactly one cycle.
- result SHALL present the full WIDTH-bit value.
- done_id SHALL identify the served requester.
REQ-013 result and done_id SHALL hold their values until the next DONE.
REQ-014 Latency: with capture at edge E0, done SHALL be high between edges E0+WIDTH and E0+WIDTH+1; the next request is sampled no earlier than edge E0+WIDTH+1.
REQ-015 A req still high when the FSM returns to IDLE SHALL be treated as a new request.
REQ-016 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-017 When WIDTH=1, RUN SHALL last exactly one cycle.
REQ-018 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap inside RUN.

Reset
REQ-019 On rst_n low, the block SHALL asynchronously force:
- state = IDLE
- gnt0 = gnt1 = busy = done = done_id = 0
- result = 0
- counter = 0
- last-served pointer = 1
REQ-020 Reset during RUN or DONE SHALL abort the operation with no done pulse; the first request after reset release SHALL be arbitrated as from a fresh start.

Structure
REQ-021 A shared package lu_pkg SHALL hold the opcode constants (OP_AND, OP_NAND, OP_OR, OP_NOR) and the FSM state type.
REQ-022 The 1-bit logic function SHALL be a purely combinational sub-module named lu_bit, with inputs a, b, ctrl1, ctrl2 and output y, instantiated once.
REQ-023 All other logic SHALL reside in lu_serial_arbiter.

Verification (WIDTH=8)
REQ-024 The bench SHALL cover these directed scenarios:
- Reset: hold rst_n low, no requests -> gnt0 = gnt1 = busy = done = 0 and result = 0x00; release with no requests -> outputs remain 0.
- req0 alone, op=00, a0=0xF0, b0=0xCC -> gnt0 pulses 1 cycle, busy for 9 cycles, done at E0+8 with result 0xC0 and done_id 0.
- req1 alone, op=11, a1=0xF0, b1=0xCC -> result 0x03, done_id 1; then op=01 with 0xFF/0xFF -> 0x00; op=10 with 0xA5/0x5A -> 0xFF.
- req0 and req1 both held high from reset release -> grants alternate 0,1,0,1 with no gap beyond the DONE cycle; done_id sequence matches; gnt0 and gnt1 never high together.
- Reset pulse while counter=3 in RUN -> busy falls immediately, no done pulse, result 0x00; the next simultaneous request is granted to req0.
- Operand change during RUN (a0 switched from 0xF0 to 0x0F after gnt0, op=00, b0=0xCC) -> result still 0xC0.

Source files
------------

// File: rtl/lu_pkg.sv
// lu_pkg: opcode constants and FSM state type shared by the serial logic-unit arbiter.
package lu_pkg;
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/lu_bit.sv
// lu_bit: 1-bit logic unit; ctrl2 picks OR over AND, ctrl1 inverts the output.
module lu_bit (
    input  logic a,
    input  logic b,
    input  logic ctrl1,
    input  logic ctrl2,
    output logic y
);
    assign y = (ctrl2 ? (a | b) : (a & b)) ^ ctrl1;
endmodule

// File: rtl/lu_serial_arbiter.sv
// lu_serial_arbiter: round-robin arbiter for two requesters feeding a bit-serial logic unit.
module lu_serial_arbiter
    import lu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r, sh, sh_nxt;
    logic             last, win, y;
    assign win = (req0 && req1) ? ~last : req1;
    lu_bit u_bit (.a(a_r[0]), .b(b_r[0]), .ctrl1(op_r[0]), .ctrl2(op_r[1]), .y(y));
    // operands shift right while results enter at the MSB, so bit i lands at position i after WIDTH steps
    assign sh_nxt = (sh >> 1) | (WIDTH'(y) << (WIDTH - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op_r    <= '0;
            a_r     <= '0;
            b_r     <= '0;
            sh      <= '0;
            last    <= 1'b1;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: if (req0 || req1) begin
                    state <= RUN;
                    busy  <= 1'b1;
                    cnt   <= '0;
                    last  <= win;
                    gnt0  <= ~win;
                    gnt1  <= win;
                    op_r  <= win ? op1 : op0;
                    a_r   <= win ? a1 : a0;
                    b_r   <= win ? b1 : b0;
                end
                RUN: begin
                    gnt0 <= 1'b0;
                    gnt1 <= 1'b0;
                    a_r  <= a_r >> 1;
                    b_r  <= b_r >> 1;
                    sh   <= sh_nxt;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        done_id <= last;
                        result  <= sh_nxt;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lu_serial_arbiter.sv
// tb_lu_serial_arbiter: word-level reference model plus directed and random checks of the serial arbiter.
module tb_lu_serial_arbiter;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [1:0]   op0 = '0, op1 = '0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         gnt0, gnt1, busy, done, done_id;
    logic [W-1:0] result;
    int n_chk = 0, n_fail = 0;
    logic         e_gnt0 = 0, e_gnt1 = 0, e_busy = 0, e_done = 0, e_id = 0, m_last = 1, m_win = 0;
    logic [W-1:0] e_res = '0, m_pend = '0;
    int           m_ph = 0;

    lu_serial_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1),
        .busy(busy), .done(done), .done_id(done_id), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] fop(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return ~(a & b);
            2'b10:   return a | b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an operation occupies the capture edge, WIDTH run edges, then one idle edge before resampling.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_ph = 0; m_last = 1; e_gnt0 = 0; e_gnt1 = 0; e_busy = 0; e_done = 0; e_id = 0; e_res = '0;
        end else if (m_ph == 0) begin
            e_gnt0 = 0; e_gnt1 = 0; e_busy = 0; e_done = 0;
            if (req0 || req1) begin
                m_win  = (req0 && req1) ? !m_last : req1;
                m_last = m_win;
                m_pend = m_win ? fop(op1, a1, b1) : fop(op0, a0, b0);
                e_gnt0 = !m_win; e_gnt1 = m_win; e_busy = 1; m_ph = 1;
            end
        end else if (m_ph < W) begin
            e_gnt0 = 0; e_gnt1 = 0; m_ph++;
        end else if (m_ph == W) begin
            e_gnt0 = 0; e_gnt1 = 0; e_done = 1; e_res = m_pend; e_id = m_win; m_ph++;
        end else begin
            e_done = 0; e_busy = 0; m_ph = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("gnt0", gnt0, e_gnt0);
        chk("gnt1", gnt1, e_gnt1);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("done_id", done_id, e_id);
        chk("result", result, e_res);
        chk("gnt_excl", gnt0 & gnt1, 0);
    end

    task automatic do_op(input bit r, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input bit scramble);
        int n, bc;
        @(negedge clk);
        if (r) begin req1 = 1; op1 = op; a1 = a; b1 = b; end
        else   begin req0 = 1; op0 = op; a0 = a; b0 = b; end
        @(negedge clk);
        chk("op_gnt", r ? gnt1 : gnt0, 1);
        chk("op_gnt_other", r ? gnt0 : gnt1, 0);
        req0 = 0; req1 = 0;
        if (scramble) begin a0 = ~a0; op0 = 2'b11; end
        n = 0; bc = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
        end
        chk("op_latency", n, W);
        chk("op_busy_cycles", bc, W + 1);
        chk("op_result", result, exp);
        chk("op_done_id", done_id, r);
        @(negedge clk);
        chk("op_done_pulse", done, 0);
        chk("op_busy_end", busy, 0);
    endtask

    initial begin
        int ng, nd, gseq[4], dseq[4], gt[4];
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_result", result, 0);

        do_op(0, 2'b00, 8'hF0, 8'hCC, 8'hC0, 0);
        do_op(1, 2'b11, 8'hF0, 8'hCC, 8'h03, 0);
        do_op(1, 2'b01, 8'hFF, 8'hFF, 8'h00, 0);
        do_op(1, 2'b10, 8'hA5, 8'h5A, 8'hFF, 0);
        do_op(0, 2'b00, 8'hF0, 8'hCC, 8'hC0, 1);

        // both requesters held from reset release
        rst_n = 0;
        @(negedge clk);
        req0 = 1; req1 = 1;
        op0 = 2'($urandom); op1 = 2'($urandom);
        a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
        @(negedge clk);
        rst_n = 1;
        ng = 0; nd = 0;
        for (int i = 0; i < 4; i++) begin gseq[i] = 2; dseq[i] = 2; gt[i] = 0; end
        for (int c = 0; c < 60 && (ng < 4 || nd < 4); c++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                if (ng < 4) begin gseq[ng] = int'(gnt1); gt[ng] = c; end
                ng++;
            end
            if (done) begin
                if (nd < 4) dseq[nd] = int'(done_id);
                nd++;
            end
        end
        req0 = 0; req1 = 0;
        for (int i = 0; i < 4; i++) begin
            chk("rr_grant_order", gseq[i], i % 2);
            chk("rr_done_id_order", dseq[i], i % 2);
        end
        for (int i = 1; i < 4; i++) chk("rr_grant_gap", gt[i] - gt[i-1], W + 2);
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        @(negedge clk);

        // reset while counter = 3, after req0 has been served
        req0 = 1; op0 = 2'b00; a0 = 8'hFF; b0 = 8'hFF;
        @(negedge clk);
        chk("abort_gnt0", gnt0, 1);
        req0 = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        repeat (2) @(negedge clk);
        req0 = 1; req1 = 1;
        rst_n = 1;
        @(negedge clk);
        chk("fresh_gnt0", gnt0, 1);
        chk("fresh_gnt1", gnt1, 0);
        req0 = 0; req1 = 0;
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);

        // random traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req0 = ($urandom % 3) == 0;
            req1 = ($urandom % 3) == 0;
            op0 = 2'($urandom); op1 = 2'($urandom);
            a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
            rst_n = ($urandom % 100) != 0;
        end
        @(negedge clk);
        req0 = 0; req1 = 0; rst_n = 1;
        repeat (15) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
